// File: rtl/restore_multiplier.sv
// restore_multiplier: rebuilds a dividend from divider outputs as Q*M + A.
// An 8-step shift-add multiply runs in CALC, A is added once in ADDR, and the
// result is then held on Pbus_out until the next completed operation or reset.
module restore_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        st,
  input  logic [7:0]  Qbus_in,
  input  logic [7:0]  Mbus_in,
  input  logic [7:0]  Abus_in,
  output logic [15:0] Pbus_out,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, CALC, ADDR, DONE} state_t;

  state_t      state_reg;
  state_t      state_next;
  logic        st_armed_reg;  // st has been sampled low since the last accepted start
  logic [7:0]  q_reg;         // multiplier; low product bits shift in from the top
  logic [7:0]  m_reg;
  logic [7:0]  a_reg;
  logic [8:0]  acc_reg;       // {carry, high product byte}
  logic [2:0]  cnt_reg;
  logic [15:0] p_reg;

  logic        accept;
  logic [7:0]  addend;
  logic [8:0]  sum;

  // A start is taken only in IDLE, and only after st has been seen low.
  assign accept = (state_reg == IDLE) && st && st_armed_reg;

  // Partial product for this step: M gated by the current multiplier LSB.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_addend
      assign addend[gi] = m_reg[gi] & q_reg[0];
    end
  endgenerate

  assign sum = acc_reg + {1'b0, addend};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: CALC runs exactly 8 edges, counted by cnt_reg.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (cnt_reg == 3'd7) state_next = ADDR;
      ADDR:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: ready is simply "in IDLE"; the result comes straight from its register.
  always_comb begin
    ready    = (state_reg == IDLE);
    Pbus_out = p_reg;
  end

  // Start-edge history; reset counts as "st seen high" so st must drop first.
  always_ff @(posedge clk) begin
    if (rst)         st_armed_reg <= 1'b0;
    else if (accept) st_armed_reg <= 1'b0;
    else if (!st)    st_armed_reg <= 1'b1;
  end

  // Datapath: latch operands, shift-add 8 times, then add A into the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= 8'h00;
      m_reg   <= 8'h00;
      a_reg   <= 8'h00;
      acc_reg <= 9'h000;
      cnt_reg <= 3'd0;
      p_reg   <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            q_reg   <= Qbus_in;
            m_reg   <= Mbus_in;
            a_reg   <= Abus_in;
            acc_reg <= 9'h000;
            cnt_reg <= 3'd0;
          end
        end
        CALC: begin
          // Shift {carry, acc, Q} right by one after the conditional add.
          acc_reg <= {1'b0, sum[8:1]};
          q_reg   <= {sum[0], q_reg[7:1]};
          cnt_reg <= cnt_reg + 3'd1;
        end
        ADDR: begin
          // Max 0xFF*0xFF + 0xFF = 0xFF00, so 16 bits never overflow.
          p_reg <= {acc_reg[7:0], q_reg} + {8'h00, a_reg};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restore_multiplier.sv
// Bench for restore_multiplier: a cycle-count model predicts ready/Pbus_out
// on every cycle, while directed operations check literal results and latency.
module tb_restore_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic [7:0]  Qbus_in;
  logic [7:0]  Mbus_in;
  logic [7:0]  Abus_in;
  logic [15:0] Pbus_out;
  logic        ready;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  restore_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .st       (st),
    .Qbus_in  (Qbus_in),
    .Mbus_in  (Mbus_in),
    .Abus_in  (Abus_in),
    .Pbus_out (Pbus_out),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  // Behavioural model: an accepted start yields Q*M+A, visible after 9 edges,
  // with ready returning after 10 edges.
  logic        m_ready;
  logic [15:0] m_p;
  logic [15:0] m_res;
  logic        m_armed;
  int          m_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_p     <= 16'h0000;
      m_armed <= 1'b0;
      m_busy  <= 0;
    end else if (m_busy == 0) begin
      if (st && m_armed) begin
        m_busy  <= 10;
        m_ready <= 1'b0;
        m_res   <= 16'(Qbus_in) * 16'(Mbus_in) + 16'(Abus_in);
        m_armed <= 1'b0;
      end else if (!st) begin
        m_armed <= 1'b1;
      end
    end else begin
      if (!st) m_armed <= 1'b1;
      m_busy <= m_busy - 1;
      if (m_busy == 2) m_p <= m_res;
      if (m_busy == 1) m_ready <= 1'b1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (ready !== m_ready || Pbus_out !== m_p) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t: ready=%b Pbus_out=%h, required ready=%b Pbus_out=%h",
                 $time, ready, Pbus_out, m_ready, m_p);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Run one operation; hold = cycles st stays high, disturb = change inputs mid-CALC,
  // rearm = raise st in the cycle before ready returns and expect acceptance one edge later.
  task automatic run_op(input logic [7:0] q, input logic [7:0] m, input logic [7:0] a,
                        input logic [15:0] exp, input int hold, input bit disturb,
                        input bit rearm, input string name);
    int lows;
    st = 1'b0;
    tick();
    Qbus_in = q; Mbus_in = m; Abus_in = a; st = 1'b1;
    tick();
    lows = 0;
    while (ready !== 1'b1 && lows < 40) begin
      lows++;
      if (lows >= hold) st = 1'b0;
      if (disturb && lows == 3) begin
        Qbus_in = 8'($urandom); Mbus_in = 8'($urandom); Abus_in = 8'($urandom);
        st = 1'b1;
      end
      if (rearm && lows == 10) st = 1'b1;
      tick();
    end
    check({name, "_busy_cycles"}, 16'(lows), 16'd10);
    check({name, "_result"}, Pbus_out, exp);
    check({name, "_model_result"}, m_p, exp);
    if (rearm) begin
      tick();
      check({name, "_rearm_accepted"}, {15'd0, ready}, 16'd0);
      st = 1'b0;
      lows = 0;
      while (ready !== 1'b1 && lows < 40) begin lows++; tick(); end
      check({name, "_rearm_result"}, Pbus_out, exp);
    end
  endtask

  initial begin
    int starts;
    bit prev;
    logic [7:0] n, d;

    rst = 1'b1; st = 1'b1; Qbus_in = 8'h00; Mbus_in = 8'h00; Abus_in = 8'h00;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_pbus", Pbus_out, 16'h0000);
    check("reset_ready", {15'd0, ready}, 16'd1);

    // st high while reset releases must not start anything.
    rst = 1'b0;
    repeat (3) tick();
    check("st_high_at_reset_release", {15'd0, ready}, 16'd1);

    run_op(8'h12, 8'h0C, 8'h03, 16'h00DB, 1, 1'b0, 1'b0, "basic_pulse1");
    run_op(8'h12, 8'h0C, 8'h03, 16'h00DB, 2, 1'b0, 1'b0, "basic_pulse2");
    run_op(8'h06, 8'h1C, 8'h14, 16'h00BC, 1, 1'b0, 1'b0, "b2b_first");
    run_op(8'h0B, 8'h13, 8'h06, 16'h00D7, 1, 1'b0, 1'b0, "b2b_second");
    run_op(8'hFF, 8'hFF, 8'hFF, 16'hFF00, 1, 1'b0, 1'b0, "corner_all_ff");
    run_op(8'h00, 8'h00, 8'h07, 16'h0007, 1, 1'b0, 1'b0, "corner_zero_m");
    run_op(8'h01, 8'hFF, 8'h00, 16'h00FF, 1, 1'b0, 1'b0, "corner_q1");
    run_op(8'h09, 8'h0E, 8'h05, 16'h0083, 1, 1'b1, 1'b0, "disturb_mid_calc");
    run_op(8'h03, 8'h05, 8'h02, 16'h0011, 1, 1'b0, 1'b1, "rearm_edge");

    // st held high for 30 cycles starts exactly one operation.
    st = 1'b0; tick();
    Qbus_in = 8'h05; Mbus_in = 8'h07; Abus_in = 8'h01; st = 1'b1;
    starts = 0; prev = ready;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (prev && !ready) starts++;
      prev = ready;
    end
    st = 1'b0;
    tick();
    check("held_st_starts", 16'(starts), 16'd1);
    check("held_st_result", Pbus_out, 16'h0024);

    // Reset at edge k+5 aborts the operation and clears the result.
    tick();
    Qbus_in = 8'h20; Mbus_in = 8'h04; Abus_in = 8'h00; st = 1'b1;
    tick();
    check("abort_started", {15'd0, ready}, 16'd0);
    st = 1'b0;
    repeat (4) tick();
    rst = 1'b1; st = 1'b1;
    tick();
    check("abort_pbus", Pbus_out, 16'h0000);
    check("abort_ready", {15'd0, ready}, 16'd1);
    rst = 1'b0;
    repeat (12) tick();
    check("abort_no_completion", Pbus_out, 16'h0000);
    run_op(8'h12, 8'h0C, 8'h03, 16'h00DB, 1, 1'b0, 1'b0, "after_abort");

    // Divider cross-check: (n / d, n % d, d) must rebuild n.
    run_op(8'hFF, 8'h01, 8'h00, 16'h00FF, 1, 1'b0, 1'b0, "xchk_255_1");
    run_op(8'h00, 8'hFF, 8'hFE, 16'h00FE, 1, 1'b0, 1'b0, "xchk_254_255");
    for (int i = 0; i < 40; i++) begin
      n = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(1, 255));
      run_op(n / d, d, n % d, {8'h00, n}, 1, 1'b0, 1'b0, "xchk_random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
